// File: rtl/des_block_packer.sv
// Packs host bytes MSB-first into 64-bit blocks, queues them in a small FIFO and
// issues one-cycle data_valid_in pulses to the 3DES datapath. Optional stats: DES_PACKER_STATS_EN.
module des_block_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ISSUE_GAP  = 0
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        flush,
    input  logic        keys_ready,
    output logic [63:0] raw_data,
    output logic        data_valid_in,
    output logic [3:0]  fifo_count
`ifdef DES_PACKER_STATS_EN
    ,
    output logic [15:0] blocks_issued
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [2:0]         byte_idx;
    logic [63:0]        pack_reg;
    logic [63:0]        pack_merged;
    logic [63:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [3:0]         gap_cnt;
    logic               accept;
    logic               push;
    logic               pop;
    logic               gap_done;

    assign byte_ready = (fifo_count < 4'(FIFO_DEPTH));
    assign accept     = byte_valid && byte_ready;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        pack_merged = pack_reg;
        if (accept) begin
            pack_merged[{~byte_idx, 3'b000} +: 8] = byte_in;
        end
    end

    // The flush path needs something in the block: either an index past 0 or a byte arriving now.
    assign push = byte_ready &&
                  ((accept && byte_idx == 3'd7) || (flush && (accept || byte_idx != 3'd0)));

    // The last GAP cycle may launch the next issue directly, so pulses sit exactly ISSUE_GAP idle cycles apart.
    assign gap_done = (gap_cnt == 4'(ISSUE_GAP - 1));
    assign pop      = (fifo_count != 4'd0) && keys_ready &&
                      (state == IDLE || (state == GAP && gap_done));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (pop) state_next = ISSUE;
            ISSUE: state_next = (ISSUE_GAP > 0) ? GAP : IDLE;
            GAP: begin
                if (pop)           state_next = ISSUE;
                else if (gap_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign data_valid_in = (state == ISSUE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            byte_idx   <= 3'd0;
            pack_reg   <= 64'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= 4'd0;
            gap_cnt    <= 4'd0;
            raw_data   <= 64'd0;
        end else begin
            state <= state_next;

            if (push) begin
                byte_idx <= 3'd0;
                pack_reg <= 64'd0;
                wr_ptr   <= wr_ptr + 1'b1;
            end else if (accept) begin
                byte_idx <= byte_idx + 3'd1;
                pack_reg <= pack_merged;
            end

            if (pop) begin
                raw_data <= fifo_mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 4'd1;
                2'b01:   fifo_count <= fifo_count - 4'd1;
                default: fifo_count <= fifo_count;
            endcase

            gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
        end
    end

    // NOTE: the FIFO storage is not reset; the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= pack_merged;
        end
    end

`ifdef DES_PACKER_STATS_EN
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            blocks_issued <= 16'd0;
        end else if (state == ISSUE) begin
            blocks_issued <= blocks_issued + 16'd1;
        end
    end
`endif

endmodule
